func_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one main_func unit (y = floor(cbrt(a + floor(sqrt(b))))) among N_REQ requesters.
- Captures the winning requester's operands and resets the unit between jobs, because main_func stays in READY until it is reset.
- Issues the start pulse, waits for ready with a timeout, and returns the result to the winner with a one-cycle done pulse.
- Sits between the requester blocks and a single main_func instance.

---
 rtl/func_share_arb.sv | 173 +++++++++++++++++
 tb/tb_func_share_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_share_arb.sv
// Round-robin arbiter that shares one main_func unit among N_REQ requesters.
// Per job: capture operands, reset the unit, pulse start, wait for ready or time out, report.
module func_share_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] a_bi,
  input  logic [8*N_REQ-1:0] b_bi,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [2:0]         y_bo,
  output logic               err_o,
  output logic               busy_o,
  output logic               unit_rst_o,
  output logic               unit_start_o,
  output logic [7:0]         unit_a_bo,
  output logic [7:0]         unit_b_bo,
  input  logic               unit_ready_i,
  input  logic [2:0]         unit_y_bi
);

  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic [2:0] {StIdle, StRst, StStart, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       ua_q, ub_q;
  logic [2:0]       y_q;
  logic             err_q;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             start_q, start_d;
  logic             rst_state_q, rst_state_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand_idx;
  logic [7:0]       a_sel, b_sel;
  logic             timeout_hit;

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand_idx = PW'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == PW'(k)) begin
        a_sel = a_bi[8*k +: 8];
        b_sel = b_bi[8*k +: 8];
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StRst;
      StRst:   state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (unit_ready_i || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pulse outputs are decoded from the upcoming state and registered.
  always_comb begin
    ack_d       = '0;
    done_d      = '0;
    start_d     = 1'b0;
    rst_state_d = 1'b0;
    if (state_q == StIdle && state_d == StRst) begin
      ack_d[win_idx] = 1'b1;
      rst_state_d    = 1'b1;
    end
    if (state_q == StRst) begin
      start_d = 1'b1;
    end
    if (state_q == StWait && state_d == StDone) begin
      done_d[ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q       <= '0;
      done_q      <= '0;
      start_q     <= 1'b0;
      rst_state_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      done_q      <= done_d;
      start_q     <= start_d;
      rst_state_q <= rst_state_d;
    end
  end

  // Job datapath: operand capture, wait counter, result latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PW'(N_REQ - 1);
      cnt_q <= '0;
      ua_q  <= '0;
      ub_q  <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            ptr_q <= win_idx;
            ua_q  <= a_sel;
            ub_q  <= b_sel;
          end
        end
        StStart: cnt_q <= '0;
        StWait: begin
          if (unit_ready_i) begin
            y_q   <= unit_y_bi;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            y_q   <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign done_o       = done_q;
  assign y_bo         = y_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != StIdle);
  assign unit_rst_o   = rst_i | rst_state_q;
  assign unit_start_o = start_q;
  assign unit_a_bo    = ua_q;
  assign unit_b_bo    = ub_q;

endmodule

// File: tb/tb_func_share_arb.sv
// Bench for func_share_arb with a behavioural main_func model and a result scoreboard.
module tb_func_share_arb;

  localparam int unsigned NReq    = 4;
  localparam int unsigned Timeout = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NReq-1:0]   req_i;
  logic [8*NReq-1:0] a_bi, b_bi;
  logic [NReq-1:0]   ack_o, done_o;
  logic [2:0]        y_bo;
  logic              err_o, busy_o, unit_rst_o, unit_start_o;
  logic [7:0]        unit_a_bo, unit_b_bo;
  logic              unit_ready_i = 1'b0;
  logic [2:0]        unit_y_bi = 3'd0;

  func_share_arb #(.N_REQ(NReq), .TIMEOUT(Timeout)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_bi(a_bi), .b_bi(b_bi),
    .ack_o(ack_o), .done_o(done_o), .y_bo(y_bo), .err_o(err_o), .busy_o(busy_o),
    .unit_rst_o(unit_rst_o), .unit_start_o(unit_start_o), .unit_a_bo(unit_a_bo),
    .unit_b_bo(unit_b_bo), .unit_ready_i(unit_ready_i), .unit_y_bi(unit_y_bi)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [2:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int r, s, c;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(b)) r++;
    s = int'(a) + r;
    c = 0;
    while ((c + 1) * (c + 1) * (c + 1) <= s) c++;
    return 3'(c);
  endfunction

  // main_func model: ready a few cycles after start, held until reset; unit_dead blocks ready.
  logic       unit_run = 1'b0;
  logic       unit_dead = 1'b0;
  int         unit_cnt = 0;
  logic [2:0] unit_res = 3'd0;
  always @(posedge clk_i) begin
    if (unit_rst_o) begin
      unit_ready_i <= 1'b0;
      unit_run     <= 1'b0;
      unit_cnt     <= 0;
      unit_y_bi    <= 3'd0;
    end else if (unit_start_o) begin
      unit_run <= 1'b1;
      unit_cnt <= 3;
      unit_res <= ref_y(unit_a_bo, unit_b_bo);
    end else if (unit_run) begin
      if (unit_cnt != 0) unit_cnt <= unit_cnt - 1;
      else if (!unit_dead) begin
        unit_ready_i <= 1'b1;
        unit_y_bi    <= unit_res;
        unit_run     <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [NReq-1:0] grant;
    logic [2:0]      y;
    logic            err;
    logic [7:0]      a;
    logic [7:0]      b;
  } exp_t;

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] y;
  } vec_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   n_checks = 0, n_pass = 0;
  int   done_cnt = 0, start_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0, rst_run = 0;
  logic [NReq-1:0] ack_seen = '0;
  logic [7:0] a_ack = 8'd0, b_ack = 8'd0;
  logic op_moved = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int onehot_idx(input logic [NReq-1:0] v);
    for (int i = 0; i < int'(NReq); i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: records grants, tracks operand stability, pops the scoreboard on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        if (unit_rst_o) rst_run++;
        if (ack_o != '0) begin
          ack_seen = ack_o;
          a_ack    = unit_a_bo;
          b_ack    = unit_b_bo;
          op_moved = 1'b0;
          grant_log.push_back(onehot_idx(ack_o));
          check("rst_with_ack", int'(unit_rst_o), 1);
        end
        if (busy_o && (unit_a_bo != a_ack || unit_b_bo != b_ack)) op_moved = 1'b1;
        if (unit_start_o) begin
          check("rst_before_start", rst_run, 1);
          rst_run = 0;
          start_cnt++;
          start_cyc = cyc;
        end
        if (done_o != '0) begin
          done_cnt++;
          done_cyc = cyc;
          if (sb_q.size() == 0) begin
            check("unexpected_done", int'(done_o), 0);
          end else begin
            e = sb_q.pop_front();
            check("done_grant", int'(done_o), int'(e.grant));
            check("ack_grant", int'(ack_seen), int'(e.grant));
            check("y", int'(y_bo), int'(e.y));
            check("err", int'(err_o), int'(e.err));
            check("unit_a", int'(a_ack), int'(e.a));
            check("unit_b", int'(b_ack), int'(e.b));
            check("ops_stable", int'(op_moved), 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    a_bi[8*k +: 8] = a;
    b_bi[8*k +: 8] = b;
  endtask

  task automatic expect_job(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] y, input logic err);
    exp_t e;
    e.grant = NReq'(1) << k;
    e.y     = y;
    e.err   = err;
    e.a     = a;
    e.b     = b;
    sb_q.push_back(e);
  endtask

  task automatic wait_grants(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (grant_log.size() >= target) return;
      @(negedge clk_i); #1;
    end
    check("ack_wait", grant_log.size(), target);
  endtask

  task automatic wait_dones(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done_cnt >= target) return;
      @(negedge clk_i); #1;
    end
    check("done_wait", done_cnt, target);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_ack", int'(ack_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_y", int'(y_bo), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_start", int'(unit_start_o), 0);
    check("rst_ua", int'(unit_a_bo), 0);
    check("rst_ub", int'(unit_b_bo), 0);
    check("rst_unit_rst", int'(unit_rst_o), 1);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
  endtask

  // Single job; operands are scrambled once acked to prove they were captured.
  task automatic run_job(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] y, input logic err);
    int tg, td;
    set_ops(k, a, b);
    expect_job(k, a, b, y, err);
    tg = grant_log.size() + 1;
    td = done_cnt + 1;
    req_i = NReq'(1) << k;
    wait_grants(tg, 10);
    req_i = '0;
    set_ops(k, 8'($urandom), 8'($urandom));
    wait_dones(td, 40);
  endtask

  initial begin
    vec_t vecs[10];
    int td, sc;
    vecs[0] = '{0, 8'd5,   8'd16,  3'd2};
    vecs[1] = '{1, 8'd20,  8'd49,  3'd3};
    vecs[2] = '{3, 8'd255, 8'd255, 3'd6};
    vecs[3] = '{2, 8'd0,   8'd0,   3'd0};
    vecs[4] = '{1, 8'd7,   8'd1,   3'd2};
    vecs[5] = '{2, 8'd100, 8'd100, 3'd4};
    vecs[6] = '{0, 8'd63,  8'd0,   3'd3};
    vecs[7] = '{3, 8'd64,  8'd0,   3'd4};
    vecs[8] = '{0, 8'd26,  8'd1,   3'd3};
    vecs[9] = '{1, 8'd0,   8'd3,   3'd1};
    req_i = '0;
    a_bi  = '0;
    b_bi  = '0;
    do_reset();

    for (int i = 0; i < 10; i++) run_job(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].y, 1'b0);

    // Timeout: unit never becomes ready; the next job must still work.
    unit_dead = 1'b1;
    run_job(0, 8'd5, 8'd16, 3'd0, 1'b1);
    check("timeout_wait_len", done_cyc - start_cyc, int'(Timeout) + 1);
    unit_dead = 1'b0;
    run_job(1, 8'd7, 8'd1, 3'd2, 1'b0);

    // Reset during WAIT: job abandoned, held request served afterwards.
    unit_dead = 1'b1;
    set_ops(2, 8'd0, 8'd0);
    sc = start_cnt + 1;
    req_i = 4'b0100;
    for (int c = 0; c < 10 && start_cnt < sc; c++) begin
      @(negedge clk_i); #1;
    end
    check("midwait_started", start_cnt, sc);
    repeat (2) @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("midwait_unit_rst", int'(unit_rst_o), 1);
    @(negedge clk_i); #1;
    check("midwait_busy", int'(busy_o), 0);
    check("midwait_done", int'(done_o), 0);
    check("midwait_y", int'(y_bo), 0);
    rst_i = 1'b0;
    unit_dead = 1'b0;
    expect_job(2, 8'd0, 8'd0, 3'd0, 1'b0);
    td = done_cnt + 1;
    wait_dones(td, 40);
    req_i = '0;

    // Simultaneous requesters 1 and 3 after reset.
    do_reset();
    set_ops(1, 8'd20, 8'd49);
    set_ops(3, 8'd255, 8'd255);
    expect_job(1, 8'd20, 8'd49, 3'd3, 1'b0);
    expect_job(3, 8'd255, 8'd255, 3'd6, 1'b0);
    expect_job(1, 8'd20, 8'd49, 3'd3, 1'b0);
    td = done_cnt + 3;
    req_i = 4'b1010;
    wait_dones(td, 100);
    req_i = '0;

    // Fairness: all four held for eight jobs.
    do_reset();
    set_ops(0, 8'd1, 8'd1);
    set_ops(1, 8'd8, 8'd0);
    set_ops(2, 8'd27, 8'd0);
    set_ops(3, 8'd200, 8'd25);
    for (int r = 0; r < 2; r++) begin
      expect_job(0, 8'd1, 8'd1, 3'd1, 1'b0);
      expect_job(1, 8'd8, 8'd0, 3'd2, 1'b0);
      expect_job(2, 8'd27, 8'd0, 3'd3, 1'b0);
      expect_job(3, 8'd200, 8'd25, 3'd5, 1'b0);
    end
    sc = start_cnt;
    td = done_cnt + 8;
    req_i = 4'b1111;
    wait_dones(td, 250);
    req_i = '0;
    check("fair_starts", start_cnt - sc, 8);

    // Late arrival: req3 rises during job 0 and is served next.
    do_reset();
    set_ops(0, 8'd63, 8'd0);
    set_ops(3, 8'd64, 8'd0);
    expect_job(0, 8'd63, 8'd0, 3'd3, 1'b0);
    expect_job(3, 8'd64, 8'd0, 3'd4, 1'b0);
    td = done_cnt + 2;
    sc = grant_log.size() + 1;
    req_i = 4'b0001;
    wait_grants(sc, 10);
    req_i = 4'b1000;
    wait_dones(td, 80);
    req_i = '0;
    repeat (4) @(negedge clk_i);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
